// File: rtl/hs_ram_arbiter.sv
// Arbitrates the work-RAM write port between the Z80 CPU and the hiscore engine.
// The CPU is paused and a settle delay elapses before the hiscore engine is granted.
module hs_ram_arbiter #(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    WIN_BASE = 'h6000,
    parameter int unsigned          WIN_BITS = 11,
    parameter int unsigned          SETTLE   = 2
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [7:0]          cpu_wdata,
    input  logic                cpu_ce,
    input  logic                cpu_we,
    output logic [7:0]          cpu_rdata,
    input  logic [ADDR_W-1:0]   hs_address,
    input  logic [7:0]          hs_data_in,
    input  logic                hs_write,
    input  logic                hs_access_read,
    input  logic                hs_access_write,
    output logic [7:0]          hs_data_out,
    input  logic                paused,
    output logic                cpu_hold,
    output logic                hs_granted,
    output logic                range_err,
    output logic [WIN_BITS-1:0] ram_addr,
    output logic [7:0]          ram_wdata,
    output logic                ram_we,
    input  logic [7:0]          ram_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StSettle,
        StGrant,
        StRelease
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [7:0]  r_hs_data;
    logic        r_hs_prev_in_win;
    logic        r_range_err;

    logic [ADDR_W-1:0] w_cpu_off;
    logic [ADDR_W-1:0] w_hs_off;
    logic              w_cpu_in_win;
    logic              w_hs_in_win;
    logic              w_intent;

    // Unsigned wrap-around makes addresses below the base land far outside the window.
    assign w_cpu_off    = cpu_addr - WIN_BASE;
    assign w_hs_off     = hs_address - WIN_BASE;
    assign w_cpu_in_win = (w_cpu_off[ADDR_W-1:WIN_BITS] == '0);
    assign w_hs_in_win  = (w_hs_off[ADDR_W-1:WIN_BITS] == '0);
    assign w_intent     = hs_access_read | hs_access_write;

    assign cpu_rdata   = ram_rdata;
    assign hs_data_out = r_hs_data;
    assign range_err   = r_range_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_intent) w_state_next = StHold;
            end
            StHold: begin
                if (!w_intent) begin
                    w_state_next = StRelease;
                end else if (paused) begin
                    if (SETTLE == 0) begin
                        w_state_next = StGrant;
                    end else begin
                        w_state_next = StSettle;
                        w_cnt_next   = 4'(SETTLE);
                    end
                end
            end
            StSettle: begin
                if (!w_intent) begin
                    w_state_next = StRelease;
                end else if (!paused) begin
                    w_state_next = StHold;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = StGrant;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StGrant: begin
                if (!w_intent) begin
                    w_state_next = StRelease;
                end else if (!paused) begin
                    w_state_next = StHold;
                end
            end
            StRelease: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        cpu_hold   = (r_state == StHold) || (r_state == StSettle) || (r_state == StGrant);
        hs_granted = (r_state == StGrant);
        ram_addr   = w_cpu_off[WIN_BITS-1:0];
        ram_wdata  = cpu_wdata;
        ram_we     = 1'b0;
        case (r_state)
            StIdle: begin
                ram_we = cpu_ce & cpu_we & w_cpu_in_win;
            end
            StGrant: begin
                ram_addr  = w_hs_off[WIN_BITS-1:0];
                ram_wdata = hs_data_in;
                // A falling pause acknowledge blocks the write in the same cycle.
                ram_we    = hs_write & w_hs_in_win & paused;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
        if (reset) ram_we = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state          <= StIdle;
            r_cnt            <= 4'd0;
            r_hs_data        <= 8'h00;
            r_hs_prev_in_win <= 1'b0;
            r_range_err      <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_hs_prev_in_win <= w_hs_in_win;
            if (r_state == StGrant) begin
                r_hs_data <= r_hs_prev_in_win ? ram_rdata : 8'h00;
                if ((hs_write | w_intent) & !w_hs_in_win) r_range_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter with a behavioural 2 KB synchronous RAM.
module tb_hs_ram_arbiter;

    logic        clk_sys;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ce;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write;
    logic        hs_access_read;
    logic        hs_access_write;
    logic [7:0]  hs_data_out;
    logic        paused;
    logic        cpu_hold;
    logic        hs_granted;
    logic        range_err;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:2047] = '{default: 8'h00};
    logic [7:0]  sb_q [$];
    int          n_checks;
    int          n_errors;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        ce;
        logic        we;
        logic        exp_we;
        logic [10:0] exp_addr;
    } cpu_vec_t;

    cpu_vec_t vecs [8];

    hs_ram_arbiter #(
        .ADDR_W   (16),
        .WIN_BASE (16'h6000),
        .WIN_BITS (11),
        .SETTLE   (2)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ce          (cpu_ce),
        .cpu_we          (cpu_we),
        .cpu_rdata       (cpu_rdata),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_write        (hs_write),
        .hs_access_read  (hs_access_read),
        .hs_access_write (hs_access_write),
        .hs_data_out     (hs_data_out),
        .paused          (paused),
        .cpu_hold        (cpu_hold),
        .hs_granted      (hs_granted),
        .range_err       (range_err),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_we          (ram_we),
        .ram_rdata       (ram_rdata)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] v);
        sb_q.push_back(v);
    endtask

    task automatic pop_check(input string name, input logic [7:0] act);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check(name, {24'd0, act}, {24'd0, sb_q.pop_front()});
        end
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
        cpu_addr = a;
        push_exp(exp);
        tick();
        #2;
        pop_check("cpu_rd", cpu_rdata);
    endtask

    // Address held for two edges; data is registered into hs_data_out by the second.
    task automatic hs_read(input logic [15:0] a, input logic [7:0] exp);
        hs_address = a;
        push_exp(exp);
        tick();
        tick();
        #2;
        pop_check("hs_rd", hs_data_out);
    endtask

    task automatic enter_grant();
        for (int i = 0; i < 20 && !hs_granted; i++) tick();
        #2;
        check("grant_wait", {31'd0, hs_granted}, 32'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        reset           = 1'b1;
        cpu_addr        = 16'h0000;
        cpu_wdata       = 8'h00;
        cpu_ce          = 1'b0;
        cpu_we          = 1'b0;
        hs_address      = 16'h6000;
        hs_data_in      = 8'h00;
        hs_write        = 1'b0;
        hs_access_read  = 1'b0;
        hs_access_write = 1'b0;
        paused          = 1'b0;

        vecs[0] = '{16'h6010, 8'hA5, 1'b1, 1'b1, 1'b1, 11'h010};
        vecs[1] = '{16'h6000, 8'h11, 1'b1, 1'b1, 1'b1, 11'h000};
        vecs[2] = '{16'h67FF, 8'h22, 1'b1, 1'b1, 1'b1, 11'h7FF};
        vecs[3] = '{16'h6800, 8'h33, 1'b1, 1'b1, 1'b0, 11'h000};
        vecs[4] = '{16'h5FFF, 8'h44, 1'b1, 1'b1, 1'b0, 11'h7FF};
        vecs[5] = '{16'h6020, 8'h55, 1'b0, 1'b1, 1'b0, 11'h020};
        vecs[6] = '{16'h6030, 8'h66, 1'b1, 1'b0, 1'b0, 11'h030};
        vecs[7] = '{16'h6100, 8'h5A, 1'b1, 1'b1, 1'b1, 11'h100};

        tick();
        tick();
        reset = 1'b0;
        #2;
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_granted", {31'd0, hs_granted}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_range_err", {31'd0, range_err}, 32'd0);
        check("rst_hs_data", {24'd0, hs_data_out}, 32'd0);
        tick();

        // CPU write table in IDLE
        for (int i = 0; i < 8; i++) begin
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].data;
            cpu_ce    = vecs[i].ce;
            cpu_we    = vecs[i].we;
            #2;
            check("cpu_we", {31'd0, ram_we}, {31'd0, vecs[i].exp_we});
            check("cpu_addr", {21'd0, ram_addr}, {21'd0, vecs[i].exp_addr});
            if (vecs[i].exp_we) check("cpu_wdata", {24'd0, ram_wdata}, {24'd0, vecs[i].data});
            tick();
        end
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        cpu_read(16'h6010, 8'hA5);
        cpu_read(16'h6000, 8'h11);
        cpu_read(16'h67FF, 8'h22);
        cpu_read(16'h6020, 8'h00);

        // Session with delayed pause acknowledge
        hs_access_write = 1'b1;
        #2;
        check("hold_not_yet", {31'd0, cpu_hold}, 32'd0);
        tick();
        #2;
        check("hold_rise", {31'd0, cpu_hold}, 32'd1);
        cpu_addr  = 16'h6010;
        cpu_wdata = 8'hFF;
        cpu_ce    = 1'b1;
        cpu_we    = 1'b1;
        #1;
        check("cpu_wr_blocked_hold", {31'd0, ram_we}, 32'd0);
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        tick();
        tick();
        paused = 1'b1;
        #2;
        check("grant_wait0", {31'd0, hs_granted}, 32'd0);
        tick();
        #2;
        check("grant_wait1", {31'd0, hs_granted}, 32'd0);
        tick();
        #2;
        check("grant_wait2", {31'd0, hs_granted}, 32'd0);
        tick();
        #2;
        check("grant_latency", {31'd0, hs_granted}, 32'd1);
        hs_address = 16'h67FF;
        hs_data_in = 8'h3C;
        hs_write   = 1'b1;
        #1;
        check("hs_we", {31'd0, ram_we}, 32'd1);
        check("hs_addr", {21'd0, ram_addr}, 32'h7FF);
        check("hs_wdata", {24'd0, ram_wdata}, 32'h3C);
        tick();
        hs_write = 1'b0;
        hs_read(16'h6100, 8'h5A);
        hs_read(16'h67FF, 8'h3C);
        hs_access_write = 1'b0;
        #1;
        check("hold_until_edge", {31'd0, cpu_hold}, 32'd1);
        tick();
        #2;
        check("release_hold", {31'd0, cpu_hold}, 32'd0);
        check("release_granted", {31'd0, hs_granted}, 32'd0);
        cpu_read(16'h6010, 8'hA5);
        cpu_read(16'h67FF, 8'h3C);

        // Out-of-window accesses and pause loss during grant
        hs_address      = 16'h6000;
        hs_access_write = 1'b1;
        tick();
        enter_grant();
        check("range_clean", {31'd0, range_err}, 32'd0);
        hs_address = 16'h6800;
        hs_data_in = 8'h77;
        hs_write   = 1'b1;
        #1;
        check("oow_we", {31'd0, ram_we}, 32'd0);
        tick();
        #2;
        check("range_set", {31'd0, range_err}, 32'd1);
        hs_write = 1'b0;
        hs_read(16'h6100, 8'h5A);
        hs_read(16'h5FFF, 8'h00);
        hs_read(16'h6000, 8'h11);
        paused     = 1'b0;
        hs_address = 16'h6040;
        hs_data_in = 8'h99;
        hs_write   = 1'b1;
        #1;
        check("pause_fall_we", {31'd0, ram_we}, 32'd0);
        tick();
        #2;
        check("pause_fall_granted", {31'd0, hs_granted}, 32'd0);
        check("pause_fall_hold", {31'd0, cpu_hold}, 32'd1);
        check("pause_fall_we2", {31'd0, ram_we}, 32'd0);
        hs_write = 1'b0;
        paused   = 1'b1;
        tick();
        #2;
        check("regrant_wait1", {31'd0, hs_granted}, 32'd0);
        tick();
        #2;
        check("regrant_wait2", {31'd0, hs_granted}, 32'd0);
        tick();
        #2;
        check("regrant", {31'd0, hs_granted}, 32'd1);
        hs_read(16'h6040, 8'h00);
        hs_access_write = 1'b0;
        tick();
        #2;
        check("range_sticky", {31'd0, range_err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check("range_cleared", {31'd0, range_err}, 32'd0);

        // Reset during SETTLE
        hs_access_read = 1'b1;
        tick();
        tick();
        #2;
        check("settle_hold", {31'd0, cpu_hold}, 32'd1);
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        hs_access_read = 1'b0;
        #2;
        check("rst_settle_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_settle_granted", {31'd0, hs_granted}, 32'd0);
        tick();

        // Reset during a granted write
        hs_address      = 16'h6000;
        hs_access_write = 1'b1;
        tick();
        enter_grant();
        hs_address = 16'h6050;
        hs_data_in = 8'hEE;
        hs_write   = 1'b1;
        reset      = 1'b1;
        #1;
        check("rst_grant_we", {31'd0, ram_we}, 32'd0);
        tick();
        reset           = 1'b0;
        hs_write        = 1'b0;
        hs_access_write = 1'b0;
        #2;
        check("rst_grant_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_grant_granted", {31'd0, hs_granted}, 32'd0);
        cpu_read(16'h6050, 8'h00);

        // Intent drop in HOLD: RELEASE then IDLE, never granted
        paused          = 1'b0;
        hs_access_write = 1'b1;
        tick();
        #2;
        check("hold2", {31'd0, cpu_hold}, 32'd1);
        hs_access_write = 1'b0;
        tick();
        cpu_addr  = 16'h6060;
        cpu_wdata = 8'hC3;
        cpu_ce    = 1'b1;
        cpu_we    = 1'b1;
        #2;
        check("rel_hold", {31'd0, cpu_hold}, 32'd0);
        check("rel_granted", {31'd0, hs_granted}, 32'd0);
        check("rel_cpu_we_dropped", {31'd0, ram_we}, 32'd0);
        tick();
        #2;
        check("idle_cpu_we", {31'd0, ram_we}, 32'd1);
        tick();
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        cpu_read(16'h6060, 8'hC3);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hs_ram_arbiter.md
# hs_ram_arbiter

Shares the single write port of the game work RAM between the Z80 CPU and the hiscore save/restore engine. On a hiscore access intent it holds the CPU through the pause path and waits for the pause acknowledge plus a settle delay. It then hands the RAM port to the hiscore engine and returns the port to the CPU when the intents drop. It sits between the core CPU bus, the hiscore module and the RAM instance, clocked on `clk_sys`.

## Interface
- `ADDR_W`, 16: width of CPU and hiscore addresses.
- `WIN_BASE`, 16'h6000: first CPU address of the arbitrated RAM window.
- `WIN_BITS`, 11: log2 of the window size (2 KB); RAM address width.
- `SETTLE`, 2: cycles to wait after `paused` rises before the grant (range 0–15).

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_ce` in 1: CPU RAM chip enable.
- `cpu_we` in 1: CPU write strobe.
- `cpu_rdata` out 8: RAM read data to the CPU.
- `hs_address` in ADDR_W: hiscore address, in the CPU address space.
- `hs_data_in` in 8: hiscore write data.
- `hs_write` in 1: hiscore write strobe.
- `hs_access_read` in 1: hiscore read intent.
- `hs_access_write` in 1: hiscore write intent.
- `hs_data_out` out 8: registered RAM read data to hiscore.
- `paused` in 1: CPU-halted acknowledge from the pause system.
- `cpu_hold` out 1: pause request to the pause system.
- `hs_granted` out 1: the hiscore engine owns the RAM port.
- `range_err` out 1: sticky flag; the hiscore engine touched an address outside the window.
- `ram_addr` out WIN_BITS: RAM address.
- `ram_wdata` out 8: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_rdata` in 8: RAM read data, one-cycle synchronous read.

## Operation
- `intent` = `hs_access_read | hs_access_write`. Read and write intents together form a single session.
- `in_win(a)` = (`a` − `WIN_BASE`) < 2^WIN_BITS, computed unsigned at ADDR_W bits. The RAM offset is the low WIN_BITS of that difference.

States:
- IDLE
  - Port mux selects the CPU: `ram_addr` = offset(`cpu_addr`), `ram_wdata` = `cpu_wdata`, `ram_we` = `cpu_ce & cpu_we & in_win(cpu_addr)`.
  - `intent` → HOLD.
- HOLD
  - `cpu_hold` = 1. `ram_we` = 0.
  - `paused` = 1 → SETTLE, with the counter loaded to SETTLE. If SETTLE = 0, go straight to GRANT.
  - `intent` falls → RELEASE.
- SETTLE
  - `cpu_hold` = 1. The counter decrements each cycle; at 1 → GRANT.
  - `paused` falls → HOLD.
  - `intent` falls → RELEASE.
- GRANT
  - `cpu_hold` = 1, `hs_granted` = 1.
  - `ram_addr` = offset(`hs_address`), `ram_wdata` = `hs_data_in`, `ram_we` = `hs_write & in_win(hs_address)`.
  - `hs_data_out` <= `ram_rdata` when the previous cycle's hiscore address was in the window; otherwise it is loaded with 8'h00.
  - `hs_write` or an intent with an address outside the window sets `range_err`.
  - `paused` falls → HOLD, with writes blocked from that cycle.
  - `intent` falls → RELEASE.
- RELEASE
  - One cycle. `cpu_hold` = 0, `ram_we` = 0, mux back to the CPU. → IDLE.
  - An intent present in RELEASE is ignored for that cycle and re-detected in IDLE.

Other rules:
- CPU writes outside IDLE are dropped. The CPU is halted then, so no queueing is required.
- `cpu_rdata` = `ram_rdata` combinationally in every state.
- `range_err` clears only on `reset`.

## Timing
Reset values:
- state IDLE
- `cpu_hold` 0, `hs_granted` 0, `ram_we` 0, `range_err` 0
- `hs_data_out` 8'h00, settle counter 0

Latencies and handshake rules:
- `cpu_hold` rises the cycle after `intent` is first sampled high in IDLE.
- Grant occurs SETTLE+1 cycles after `paused` is sampled high in HOLD, i.e. `hs_granted` rises at that edge.
- Hiscore read latency: `hs_address` presented at cycle N (granted) → `hs_data_out` valid after edge N+2. The hiscore engine holds the address for at least 2 cycles per read.
- Hiscore write: `ram_we` is combinational in the same cycle as `hs_write`.
- Release: `cpu_hold` and `hs_granted` fall one cycle after `intent` falls. The CPU mux is restored that same cycle.
- `reset` mid-session: the next state is IDLE, `cpu_hold` drops, and any in-flight write is suppressed in the reset cycle.

## Test plan
- Reset with all inputs 0 → all outputs at reset values. A CPU write at 16'h6010 with data 8'hA5 → `ram_we`=1, `ram_addr`=11'h010; a read back returns 8'hA5 one cycle later.
- `hs_access_write`=1, `paused` rising 3 cycles later, SETTLE=2 → `cpu_hold` high at cycle 1; `hs_granted` high exactly 3 cycles after `paused`. `hs_write` at 16'h67FF with 8'h3C → RAM[11'h7FF]=8'h3C.
- Granted read of 16'h6100 holding 8'h5A → `hs_data_out`=8'h5A after 2 edges. An intent drop then → `cpu_hold` 0 one cycle later, and a CPU read sees the RAM again.
- Granted `hs_write` at 16'h6800 (outside the window) → `ram_we`=0 and `range_err`=1. Reading 16'h5FFF → `hs_data_out`=8'h00. `range_err` stays set until `reset`.
- `paused` falls during GRANT → `hs_granted` 0 and `ram_we` 0 next cycle, state HOLD. `paused` rises again → grant after SETTLE+1.
- `reset` asserted during SETTLE, and separately during a GRANT write → next cycle IDLE, `cpu_hold` 0, no RAM write in the reset cycle. `intent` falling in HOLD → RELEASE then IDLE with no grant.
